// File: rtl/memory_stage.sv
// memory_stage: SPARC-V8 memory stage sitting between execute and writeback.
// Accepts one execute record at a time, runs at most one load/store on the
// req/resp data port, and emits a single registered writeback record per
// instruction. Non-memory ops and misaligned accesses complete in one cycle
// without leaving IDLE, so they run at full throughput.
module memory_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] MEM_alures_in,
  input  logic [DATA_WIDTH-1:0] MEM_valD_in,
  input  logic [1:0]            MEM_op_in,
  input  logic [2:0]            MEM_op2_in,
  input  logic [5:0]            MEM_op3_in,
  input  logic [REG_BITS-1:0]   MEM_regD_in,
  output logic                  mem_ready,
  output logic                  dreq_valid,
  input  logic                  dreq_ready,
  output logic [DATA_WIDTH-1:0] dreq_addr,
  output logic                  dreq_we,
  output logic [DATA_WIDTH-1:0] dreq_wdata,
  output logic [3:0]            dreq_be,
  input  logic                  dresp_valid,
  input  logic [DATA_WIDTH-1:0] dresp_rdata,
  output logic                  WB_valid_out,
  output logic                  WB_wen_out,
  output logic [REG_BITS-1:0]   WB_regD_out,
  output logic [DATA_WIDTH-1:0] WB_val_out,
  output logic                  mem_trap_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } mem_size_t;

  state_t state;

  // Decoded view of the incoming execute record
  logic            is_load;
  logic            is_store;
  logic            is_signed;
  mem_size_t       acc_size;
  logic            misaligned;
  logic            nonmem_wen;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;

  // Fields of the outstanding transaction needed to format the load result
  logic [REG_BITS-1:0] cap_rd;
  mem_size_t           cap_size;
  logic                cap_signed;
  logic [1:0]          cap_lo;

  // Load result after lane selection and extension
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_val;

  // The stage only takes a new record in IDLE; the bus request is live only in REQ
  assign mem_ready  = (state == IDLE);
  assign dreq_valid = (state == REQ);

  // Decode op/op3 into load/store class, access size and signedness
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    acc_size  = SZ_WORD;
    if (MEM_op_in == 2'b11) begin
      case (MEM_op3_in)
        6'b000000: begin is_load  = 1'b1; acc_size = SZ_WORD; end
        6'b000001: begin is_load  = 1'b1; acc_size = SZ_BYTE; end
        6'b000010: begin is_load  = 1'b1; acc_size = SZ_HALF; end
        6'b001001: begin is_load  = 1'b1; acc_size = SZ_BYTE; is_signed = 1'b1; end
        6'b001010: begin is_load  = 1'b1; acc_size = SZ_HALF; is_signed = 1'b1; end
        6'b000100: begin is_store = 1'b1; acc_size = SZ_WORD; end
        6'b000101: begin is_store = 1'b1; acc_size = SZ_BYTE; end
        6'b000110: begin is_store = 1'b1; acc_size = SZ_HALF; end
        default:   begin is_load  = 1'b0; end
      endcase
    end
  end

  // Alignment check, big-endian byte enables and lane-replicated store data
  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = MEM_valD_in;
    case (acc_size)
      SZ_BYTE: begin
        be_next    = 4'b1000 >> MEM_alures_in[1:0];
        wdata_next = {4{MEM_valD_in[7:0]}};
      end
      SZ_HALF: begin
        misaligned = MEM_alures_in[0];
        be_next    = MEM_alures_in[1] ? 4'b0011 : 4'b1100;
        wdata_next = {2{MEM_valD_in[15:0]}};
      end
      default: begin
        misaligned = (MEM_alures_in[1:0] != 2'b00);
        be_next    = 4'b1111;
        wdata_next = MEM_valD_in;
      end
    endcase
  end

  // Register-file write enable for non-memory ops: arithmetic (op=10) or SETHI (op=00, op2=100)
  always_comb begin
    nonmem_wen = ((MEM_op_in == 2'b10) ||
                  ((MEM_op_in == 2'b00) && (MEM_op2_in == 3'b100))) &&
                 (MEM_regD_in != '0);
  end

  // Pick the addressed lane of the big-endian read word and extend it
  always_comb begin
    case (cap_lo)
      2'd0:    byte_lane = dresp_rdata[31:24];
      2'd1:    byte_lane = dresp_rdata[23:16];
      2'd2:    byte_lane = dresp_rdata[15:8];
      default: byte_lane = dresp_rdata[7:0];
    endcase
    half_lane = cap_lo[1] ? dresp_rdata[15:0] : dresp_rdata[31:16];
    case (cap_size)
      SZ_BYTE: load_val = cap_signed ? {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane}
                                     : {{(DATA_WIDTH-8){1'b0}}, byte_lane};
      SZ_HALF: load_val = cap_signed ? {{(DATA_WIDTH-16){half_lane[15]}}, half_lane}
                                     : {{(DATA_WIDTH-16){1'b0}}, half_lane};
      default: load_val = dresp_rdata;
    endcase
  end

  // Control FSM: accept in IDLE, hold the request in REQ, wait for the response in WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dreq_addr    <= '0;
      dreq_we      <= 1'b0;
      dreq_wdata   <= '0;
      dreq_be      <= 4'b0000;
      WB_valid_out <= 1'b0;
      WB_wen_out   <= 1'b0;
      WB_regD_out  <= '0;
      WB_val_out   <= '0;
      mem_trap_out <= 1'b0;
      cap_rd       <= '0;
      cap_size     <= SZ_WORD;
      cap_signed   <= 1'b0;
      cap_lo       <= 2'b00;
    end else begin
      WB_valid_out <= 1'b0;
      mem_trap_out <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_ready) begin
            if (!(is_load || is_store)) begin
              WB_valid_out <= 1'b1;
              WB_wen_out   <= nonmem_wen;
              WB_regD_out  <= MEM_regD_in;
              WB_val_out   <= MEM_alures_in;
            end else if (misaligned) begin
              WB_valid_out <= 1'b1;
              WB_wen_out   <= 1'b0;
              WB_regD_out  <= MEM_regD_in;
              WB_val_out   <= MEM_alures_in;
              mem_trap_out <= 1'b1;
            end else begin
              state      <= REQ;
              dreq_addr  <= {MEM_alures_in[DATA_WIDTH-1:2], 2'b00};
              dreq_we    <= is_store;
              dreq_wdata <= wdata_next;
              dreq_be    <= be_next;
              cap_rd     <= MEM_regD_in;
              cap_size   <= acc_size;
              cap_signed <= is_signed;
              cap_lo     <= MEM_alures_in[1:0];
            end
          end
        end
        REQ: begin
          if (dreq_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (dresp_valid) begin
            state        <= IDLE;
            WB_valid_out <= 1'b1;
            WB_regD_out  <= cap_rd;
            if (dreq_we) begin
              WB_wen_out <= 1'b0;
              WB_val_out <= dreq_wdata;
            end else begin
              WB_wen_out <= (cap_rd != '0);
              WB_val_out <= load_val;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
